rr_arbiter_2ch: RTL

//  Two-requester round-robin arbiter with grant hold, owner release and a hold-limit timeout.

---
 rtl/rr_arbiter_2ch.sv | 74 +++++++
 1 files changed

// File: rtl/rr_arbiter_2ch.sv
// rr_arbiter_2ch: two-channel round-robin arbiter with grant hold, owner release and hold-limit timeout
module rr_arbiter_2ch #(
  parameter int HOLD_MAX = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          done,
  output logic          gnt_valid,
  output logic          gnt_idx,
  output logic          last_idx,
  output logic [CW-1:0] hold_cnt,
  output logic          timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state_q, state_d;
  logic gnt_valid_q, gnt_valid_d, gnt_idx_q, gnt_idx_d, last_idx_q, last_idx_d, timeout_q, timeout_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic owner_req, at_limit, rel, winner;
  assign owner_req = gnt_idx_q ? req1 : req0;
  assign at_limit  = hold_cnt_q == CW'(HOLD_MAX - 1);
  assign rel       = done | ~owner_req | at_limit;
  assign winner    = (req0 & req1) ? ~last_idx_q : req1;
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    last_idx_d  = last_idx_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    if (state_q == GRANT) begin
      if (rel) begin
        state_d     = GAP;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        timeout_d   = at_limit & ~done & owner_req;
      end else begin
        hold_cnt_d  = hold_cnt_q + 1'b1;
      end
    end else if (req0 | req1) begin
      state_d     = GRANT;
      gnt_valid_d = 1'b1;
      gnt_idx_d   = winner;
      last_idx_d  = winner;
      hold_cnt_d  = '0;
    end else begin
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= 1'b0;
      last_idx_q  <= 1'b1;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      last_idx_q  <= last_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign last_idx  = last_idx_q;
  assign hold_cnt  = hold_cnt_q;
  assign timeout   = timeout_q;
endmodule
